// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared ALU op encoding and word width.
// Imported by the ALU and the control decoder.
package mips_alu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_NOR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/mips_alu_core.sv
// mips_alu_core: combinational result, zero and overflow.
// Overflow output exists only when ALU_OVERFLOW_EN is defined.
module mips_alu_core
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [2:0]       i_op,
    input  logic [4:0]       i_shamt,
`ifdef ALU_OVERFLOW_EN
    output logic             o_ovf,
`endif
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_sum  = i_in1 + i_in2;
    assign w_diff = i_in1 - i_in2;
    // True signed compare so SLT stays correct when SUB overflows
    assign w_lt   = $signed(i_in1) < $signed(i_in2);

    always_comb begin
        o_result = '0;
        case (alu_op_e'(i_op))
            ALU_ADD: o_result = w_sum;
            ALU_SUB: o_result = w_diff;
            ALU_AND: o_result = i_in1 & i_in2;
            ALU_OR:  o_result = i_in1 | i_in2;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            ALU_SLL: o_result = i_in2 << i_shamt;
            ALU_SRL: o_result = i_in2 >> i_shamt;
            ALU_NOR: o_result = ~(i_in1 | i_in2);
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

`ifdef ALU_OVERFLOW_EN
    logic w_a_s;
    logic w_b_s;

    assign w_a_s = i_in1[WIDTH-1];
    assign w_b_s = i_in2[WIDTH-1];

    always_comb begin
        o_ovf = 1'b0;
        case (alu_op_e'(i_op))
            ALU_ADD: o_ovf = (w_a_s == w_b_s)
                           && (w_sum[WIDTH-1] != w_a_s);
            ALU_SUB: o_ovf = (w_a_s != w_b_s)
                           && (w_diff[WIDTH-1] != w_a_s);
            default: o_ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit MIPS ALU, one cycle latency.
// Optional overflow port under ALU_OVERFLOW_EN.
module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    input  logic [2:0]       alu_op,
    input  logic [4:0]       shamt,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zout
);

    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zout;

`ifdef ALU_OVERFLOW_EN
    logic w_ovf;
    logic r_ovf;
`endif

    mips_alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_in1   (alu_in1),
        .i_in2   (alu_in2),
        .i_op    (alu_op),
        .i_shamt (shamt),
`ifdef ALU_OVERFLOW_EN
        .o_ovf   (w_ovf),
`endif
        .o_result(w_result),
        .o_zero  (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_zout  <= 1'b1;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out  <= w_result;
                r_zout <= w_zero;
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

    assign out_valid = r_valid;
    assign alu_out   = r_out;
    assign alu_zout  = r_zout;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: vector table, corner sequences and random ops
// checked against an arithmetic reference model.
module tb_mips_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  alu_op;
    logic [4:0]  shamt;
    logic        out_valid;
    logic [31:0] alu_out;
    logic        alu_zout;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;

    mips_alu dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_op   (alu_op),
        .shamt    (shamt),
`ifdef ALU_OVERFLOW_EN
        .overflow (overflow),
`endif
        .out_valid(out_valid),
        .alu_out  (alu_out),
        .alu_zout (alu_zout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the op rules
    function automatic logic [31:0] ref_res(
        input logic [2:0] op, input logic [31:0] a,
        input logic [31:0] b, input logic [4:0] sh);
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p2 = 64'sd1 << sh;
        longint m  = 64'sd1 << 32;
        case (op)
            3'd0: return 32'((ua + ub) % m);
            3'd1: return 32'((ua + m - ub) % m);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (sa < sb) ? 32'd1 : 32'd0;
            3'd5: return 32'((ub * p2) % m);
            3'd6: return 32'(ub / p2);
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic ref_ovf(
        input logic [2:0] op, input logic [31:0] a,
        input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        if (op == 3'd0) r = sa + sb;
        else if (op == 3'd1) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        in_valid = v;
        alu_op   = op;
        alu_in1  = a;
        alu_in2  = b;
        shamt    = sh;
    endtask

    task automatic expect_out(input string tag,
                              input logic v,
                              input logic [31:0] r,
                              input logic z,
                              input logic o);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".out"}, alu_out, r);
        chk({tag, ".zout"}, {31'b0, alu_zout}, {31'b0, z});
`ifdef ALU_OVERFLOW_EN
        chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, o});
`else
        if (o === 1'bx) $display("unexpected x flag");
`endif
    endtask

    vec_t vt[$];

    initial begin
        logic [31:0] last_r;
        logic        last_z;
        logic        last_o;

        vt.push_back('{3'd0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0});
        vt.push_back('{3'd0, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0});
        vt.push_back('{3'd1, 32'd3, 32'd3, 5'd0, 32'd0, 1'b1, 1'b0});
        vt.push_back('{3'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0, 1'b1});
        vt.push_back('{3'd1, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1});
        vt.push_back('{3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0});
        vt.push_back('{3'd3, 32'h0F0F0000, 32'h000000F0, 5'd0, 32'h0F0F00F0, 1'b0, 1'b0});
        vt.push_back('{3'd7, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0});
        vt.push_back('{3'd4, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0});
        vt.push_back('{3'd4, 32'h80000000, 32'h7FFFFFFF, 5'd0, 32'd1, 1'b0, 1'b0});
        vt.push_back('{3'd4, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 1'b0});
        vt.push_back('{3'd5, 32'hFFFFFFFF, 32'd1, 5'd31, 32'h80000000, 1'b0, 1'b0});
        vt.push_back('{3'd6, 32'd0, 32'h80000000, 5'd31, 32'd1, 1'b0, 1'b0});
        vt.push_back('{3'd6, 32'hDEADBEEF, 32'h12345678, 5'd0, 32'h12345678, 1'b0, 1'b0});
        vt.push_back('{3'd0, 32'd1, 32'd2, 5'd7, 32'd3, 1'b0, 1'b0});

        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        #1;
        expect_out("reset", 1'b0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back table: each result one cycle after issue
        for (int i = 0; i < vt.size(); i++) begin
            drive(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].sh);
            @(posedge clk);
            #1;
            expect_out($sformatf("vec%0d", i), 1'b1,
                       vt[i].res, vt[i].z, vt[i].ovf);
        end

        // Idle cycles hold the last result
        drive(1'b0, 3'd7, 32'd0, 32'd0, 5'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            expect_out("hold", 1'b0, 32'd3, 1'b0, 1'b0);
        end

        // Async reset between edges with an op pending
        drive(1'b1, 3'd7, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_out("midrst", 1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        expect_out("inrst", 1'b0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 3'd1, 32'd10, 32'd4, 5'd0);
        @(posedge clk);
        #1;
        expect_out("postrst", 1'b1, 32'd6, 1'b0, 1'b0);

        // Random ops with random bubbles
        last_r = 32'd6;
        last_z = 1'b0;
        last_o = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic        v;
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  sh;
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            sh = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 7) == 0) a = {a[31], 31'h7FFFFFFF};
            drive(v, op, a, b, sh);
            @(posedge clk);
            #1;
            if (v) begin
                last_r = ref_res(op, a, b, sh);
                last_z = (last_r == 32'd0);
                last_o = ref_ovf(op, a, b);
            end
            expect_out("rand", v, last_r, last_z, last_o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
